// File: rtl/ps2_pkg.sv
// Shared PS/2 scan-code constants, seven-segment table, frame FSM states and status codes.
package ps2_pkg;

  localparam logic [7:0] SC_BREAK = 8'hF0;
  localparam logic [7:0] SC_EXT   = 8'hE0;

  // Make codes for hex keys 0..F, indexed by the digit value
  localparam logic [7:0] SC_HEX [16] = '{
    8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D,
    8'h3E, 8'h46, 8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B
  };

  localparam logic [7:0] SEG_LUT [16] = '{
    8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
    8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71
  };

  localparam logic [3:0] ST_IDLE     = 4'b0000;
  localparam logic [3:0] ST_MATCH    = 4'b1010;
  localparam logic [3:0] ST_MISMATCH = 4'b1011;

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} rx_state_e;

  typedef struct packed {
    logic       hit;
    logic [3:0] nib;
  } hex_key_t;

  function automatic hex_key_t hex_decode(input logic [7:0] sc);
    hex_key_t r;
    r = '0;
    for (int i = 0; i < 16; i++) begin
      if (sc == SC_HEX[i]) begin
        r.hit = 1'b1;
        r.nib = 4'(i);
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/ps2_frame_rx.sv
// PS/2 frame receiver: synchroniser, kbclk falling-edge detect, 11-bit frame FSM and timeout.
// Parity is enforced only when PS2_PARITY_CHK_EN is defined.
module ps2_frame_rx
  import ps2_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT_CYC = 5000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       kbclk,
  input  logic       kbdata,
  output logic [7:0] rx_byte,
  output logic       byte_vld,
  output logic       frame_err
);

  localparam int CW = $clog2(TIMEOUT_CYC + 1);

  logic [SYNC_STAGES-1:0] kbclk_sync_q, kbclk_sync_d;
  logic [SYNC_STAGES-1:0] kbdata_sync_q, kbdata_sync_d;
  logic                   kbclk_prev_q, kbclk_prev_d;
  rx_state_e              state_q, state_d;
  logic [2:0]             bit_idx_q, bit_idx_d;
  logic [7:0]             shift_q, shift_d;
  logic                   par_q, par_d;
  logic [CW-1:0]          to_cnt_q, to_cnt_d;
  logic [7:0]             byte_q, byte_d;
  logic                   byte_vld_q, byte_vld_d;
  logic                   frame_err_q, frame_err_d;

  logic fall, din, par_ok, timeout;

  always_comb begin
    kbclk_sync_d  = {kbclk_sync_q[SYNC_STAGES-2:0], kbclk};
    kbdata_sync_d = {kbdata_sync_q[SYNC_STAGES-2:0], kbdata};
    kbclk_prev_d  = kbclk_sync_q[SYNC_STAGES-1];
    fall          = kbclk_prev_q & ~kbclk_sync_q[SYNC_STAGES-1];
    din           = kbdata_sync_q[SYNC_STAGES-1];
`ifdef PS2_PARITY_CHK_EN
    par_ok        = ^{par_q, shift_q};
`else
    par_ok        = 1'b1;
`endif
    timeout       = (state_q != IDLE) && !fall && (to_cnt_q == CW'(TIMEOUT_CYC - 1));

    state_d     = state_q;
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    par_d       = par_q;
    byte_d      = byte_q;
    byte_vld_d  = 1'b0;
    frame_err_d = 1'b0;

    if (state_q == IDLE || fall) to_cnt_d = '0;
    else                         to_cnt_d = to_cnt_q + CW'(1);

    if (timeout) begin
      state_d     = IDLE;
      frame_err_d = 1'b1;
      to_cnt_d    = '0;
    end else if (fall) begin
      case (state_q)
        IDLE: begin
          if (!din) begin
            state_d   = DATA;
            bit_idx_d = 3'd0;
          end
        end
        DATA: begin
          shift_d   = {din, shift_q[7:1]};
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) state_d = PARITY;
        end
        PARITY: begin
          par_d   = din;
          state_d = STOP;
        end
        STOP: begin
          state_d = IDLE;
          if (din && par_ok) begin
            byte_d     = shift_q;
            byte_vld_d = 1'b1;
          end else begin
            frame_err_d = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      kbclk_sync_q  <= '1;
      kbdata_sync_q <= '1;
      kbclk_prev_q  <= 1'b1;
      state_q       <= IDLE;
      bit_idx_q     <= '0;
      shift_q       <= '0;
      par_q         <= 1'b0;
      to_cnt_q      <= '0;
      byte_q        <= '0;
      byte_vld_q    <= 1'b0;
      frame_err_q   <= 1'b0;
    end else begin
      kbclk_sync_q  <= kbclk_sync_d;
      kbdata_sync_q <= kbdata_sync_d;
      kbclk_prev_q  <= kbclk_prev_d;
      state_q       <= state_d;
      bit_idx_q     <= bit_idx_d;
      shift_q       <= shift_d;
      par_q         <= par_d;
      to_cnt_q      <= to_cnt_d;
      byte_q        <= byte_d;
      byte_vld_q    <= byte_vld_d;
      frame_err_q   <= frame_err_d;
    end
  end

  assign rx_byte   = byte_q;
  assign byte_vld  = byte_vld_q;
  assign frame_err = frame_err_q;

endmodule

// File: rtl/ps2_code_lock.sv
// PS/2 code lock top: break filtering, hex decode to 7-seg, reference/entry buffers and compare.
// Optional macro PS2_PARITY_CHK_EN (used in ps2_frame_rx) enables parity rejection.
module ps2_code_lock
  import ps2_pkg::*;
#(
  parameter int CODE_LEN    = 4,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT_CYC = 5000
) (
  input  logic                            clkin,
  input  logic                            rst,
  input  logic                            kbclk,
  input  logic                            kbdata,
  input  logic                            flag,
  output logic [7:0]                      dout,
  output logic [3:0]                      jgout,
  output logic                            key_vld,
  output logic                            frame_err,
  output logic [$clog2(CODE_LEN+1)-1:0]   dig_cnt
);

  localparam int CNT_W = $clog2(CODE_LEN + 1);
  localparam int BUF_W = 4 * CODE_LEN;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(CODE_LEN);

  logic [7:0] rx_byte;
  logic       rx_vld;

  ps2_frame_rx #(
    .SYNC_STAGES (SYNC_STAGES),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_rx (
    .clk       (clkin),
    .rst_n     (rst),
    .kbclk     (kbclk),
    .kbdata    (kbdata),
    .rx_byte   (rx_byte),
    .byte_vld  (rx_vld),
    .frame_err (frame_err)
  );

  logic             flag_s_q, flag_s_d;
  logic             flag_prev_q, flag_prev_d;
  logic             brk_q, brk_d;
  logic [7:0]       dout_q, dout_d;
  logic [3:0]       jgout_q, jgout_d;
  logic             key_vld_q, key_vld_d;
  logic [CNT_W-1:0] dig_cnt_q, dig_cnt_d;
  logic [BUF_W-1:0] entry_q, entry_d;
  logic [BUF_W-1:0] ref_q, ref_d;
  logic             flag_chg;
  hex_key_t         key;

  always_comb begin
    flag_s_d    = flag;
    flag_prev_d = flag_s_q;
    flag_chg    = flag_s_q ^ flag_prev_q;
    key         = hex_decode(rx_byte);

    brk_d     = brk_q;
    dout_d    = dout_q;
    jgout_d   = jgout_q;
    key_vld_d = 1'b0;
    dig_cnt_d = dig_cnt_q;
    entry_d   = entry_q;
    ref_d     = ref_q;

    // The byte after a break code is the released key and carries no digit
    if (rx_vld) begin
      if (brk_q) begin
        brk_d = 1'b0;
      end else if (rx_byte == SC_EXT) begin
        brk_d = 1'b0;
      end else if (rx_byte == SC_BREAK) begin
        brk_d = 1'b1;
      end else if (!key.hit) begin
        dout_d = 8'h00;
      end else if (!flag_chg) begin
        dout_d    = SEG_LUT[key.nib];
        key_vld_d = 1'b1;
        if (flag_s_q) begin
          ref_d = (ref_q << 4) | BUF_W'(key.nib);
          if (dig_cnt_q != FULL) dig_cnt_d = dig_cnt_q + CNT_W'(1);
        end else if (dig_cnt_q == FULL) begin
          entry_d   = BUF_W'(key.nib);
          dig_cnt_d = CNT_W'(1);
          jgout_d   = ST_IDLE;
        end else begin
          entry_d   = (entry_q << 4) | BUF_W'(key.nib);
          dig_cnt_d = dig_cnt_q + CNT_W'(1);
          if (dig_cnt_q == FULL - CNT_W'(1))
            jgout_d = (entry_d == ref_q) ? ST_MATCH : ST_MISMATCH;
        end
      end
    end

    // A mode switch always starts a clean entry; the reference survives
    if (flag_chg) begin
      dig_cnt_d = '0;
      entry_d   = '0;
      jgout_d   = ST_IDLE;
    end
    if (flag_s_q) jgout_d = ST_IDLE;
  end

  always_ff @(posedge clkin or negedge rst) begin
    if (!rst) begin
      flag_s_q    <= 1'b0;
      flag_prev_q <= 1'b0;
      brk_q       <= 1'b0;
      dout_q      <= '0;
      jgout_q     <= ST_IDLE;
      key_vld_q   <= 1'b0;
      dig_cnt_q   <= '0;
      entry_q     <= '0;
      ref_q       <= '0;
    end else begin
      flag_s_q    <= flag_s_d;
      flag_prev_q <= flag_prev_d;
      brk_q       <= brk_d;
      dout_q      <= dout_d;
      jgout_q     <= jgout_d;
      key_vld_q   <= key_vld_d;
      dig_cnt_q   <= dig_cnt_d;
      entry_q     <= entry_d;
      ref_q       <= ref_d;
    end
  end

  assign dout    = dout_q;
  assign jgout   = jgout_q;
  assign key_vld = key_vld_q;
  assign dig_cnt = dig_cnt_q;

endmodule

// File: tb/tb_ps2_code_lock.sv
// Self-checking bench for ps2_code_lock: table of key presses, corner sequences, random bytes vs model.
`timescale 1ns/1ps
module tb_ps2_code_lock;

  localparam int CODE_LEN = 4;
  localparam int TO       = 5000;
  localparam int HALF     = 10;

  localparam logic [7:0] HEXC [16] = '{
    8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D,
    8'h3E, 8'h46, 8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B
  };
  localparam logic [7:0] SEGS [16] = '{
    8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
    8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71
  };
  localparam longint unsigned MASK = (64'd1 << (4 * CODE_LEN)) - 64'd1;

  logic       clkin = 1'b0;
  logic       rst = 1'b0;
  logic       kbclk = 1'b1;
  logic       kbdata = 1'b1;
  logic       flag = 1'b0;
  logic [7:0] dout;
  logic [3:0] jgout;
  logic       key_vld;
  logic       frame_err;
  logic [2:0] dig_cnt;

  ps2_code_lock #(.CODE_LEN(CODE_LEN), .SYNC_STAGES(2), .TIMEOUT_CYC(TO)) dut (
    .clkin     (clkin),
    .rst       (rst),
    .kbclk     (kbclk),
    .kbdata    (kbdata),
    .flag      (flag),
    .dout      (dout),
    .jgout     (jgout),
    .key_vld   (key_vld),
    .frame_err (frame_err),
    .dig_cnt   (dig_cnt)
  );

  always #5 clkin = ~clkin;

  int n_cmp = 0;
  int n_bad = 0;
  int key_cnt = 0;
  int ferr_cnt = 0;

  always @(negedge clkin) begin
    if (key_vld)   key_cnt++;
    if (frame_err) ferr_cnt++;
  end

  // Reference model state
  int              m_keys = 0;
  int              m_ferr = 0;
  int              m_cnt;
  logic [7:0]      m_dout;
  logic [3:0]      m_jg;
  bit              m_brk;
  bit              m_flag = 1'b0;
  longint unsigned m_ref, m_ent;

  task automatic model_reset();
    m_cnt = 0; m_dout = 8'h00; m_jg = 4'h0; m_brk = 1'b0; m_ref = 0; m_ent = 0;
  endtask

  task automatic model_byte(input logic [7:0] b);
    int idx;
    idx = -1;
    if (m_brk) begin m_brk = 1'b0; return; end
    if (b == 8'hE0) return;
    if (b == 8'hF0) begin m_brk = 1'b1; return; end
    for (int i = 0; i < 16; i++) if (HEXC[i] == b) idx = i;
    if (idx < 0) begin m_dout = 8'h00; return; end
    m_dout = SEGS[idx];
    m_keys++;
    if (m_flag) begin
      m_ref = ((m_ref << 4) | longint'(idx)) & MASK;
      if (m_cnt < CODE_LEN) m_cnt++;
      m_jg = 4'h0;
    end else begin
      if (m_cnt == CODE_LEN) begin m_ent = 0; m_cnt = 0; m_jg = 4'h0; end
      m_ent = ((m_ent << 4) | longint'(idx)) & MASK;
      m_cnt++;
      if (m_cnt == CODE_LEN) m_jg = (m_ent == m_ref) ? 4'hA : 4'hB;
    end
  endtask

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic check_model(input string tag);
    check({tag, ".dout"},    64'(dout),     64'(m_dout));
    check({tag, ".jgout"},   64'(jgout),    64'(m_jg));
    check({tag, ".dig_cnt"}, 64'(dig_cnt),  64'(m_cnt));
    check({tag, ".keys"},    64'(key_cnt),  64'(m_keys));
    check({tag, ".ferr"},    64'(ferr_cnt), 64'(m_ferr));
  endtask

  task automatic check_reset(input string tag);
    check({tag, ".dout"},      64'(dout),      64'h00);
    check({tag, ".jgout"},     64'(jgout),     64'h0);
    check({tag, ".dig_cnt"},   64'(dig_cnt),   64'h0);
    check({tag, ".key_vld"},   64'(key_vld),   64'h0);
    check({tag, ".frame_err"}, 64'(frame_err), 64'h0);
  endtask

  function automatic logic [10:0] mkframe(input logic [7:0] b, input bit bad);
    logic p;
    p = ~(^b) ^ bad;
    return {1'b1, p, b, 1'b0};
  endfunction

  task automatic send_bits(input logic [10:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clkin); kbdata = bits[i];
      repeat (HALF) @(negedge clkin); kbclk = 1'b0;
      repeat (HALF) @(negedge clkin); kbclk = 1'b1;
    end
    repeat (HALF) @(negedge clkin);
    kbdata = 1'b1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    send_bits(mkframe(b, 1'b0), 11);
    model_byte(b);
  endtask

  task automatic press(input logic [7:0] b);
    send_byte(b);
    send_byte(8'hF0);
    send_byte(b);
  endtask

  task automatic set_flag(input bit v);
    if (v != m_flag) begin
      flag = v;
      repeat (6) @(negedge clkin);
      m_flag = v; m_ent = 0; m_cnt = 0; m_jg = 4'h0;
    end
  endtask

  typedef struct {
    logic [7:0] code;
    bit         fl;
    logic [7:0] e_dout;
    logic [3:0] e_jg;
    int         e_cnt;
  } vec_t;

  vec_t tbl [13];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    int kb, fe, c, wait_cyc;
    logic [7:0] b;

    tbl[0]  = '{8'h16, 1'b1, 8'h06, 4'h0, 1};
    tbl[1]  = '{8'h1E, 1'b1, 8'h5B, 4'h0, 2};
    tbl[2]  = '{8'h26, 1'b1, 8'h4F, 4'h0, 3};
    tbl[3]  = '{8'h25, 1'b1, 8'h66, 4'h0, 4};
    tbl[4]  = '{8'h16, 1'b0, 8'h06, 4'h0, 1};
    tbl[5]  = '{8'h1E, 1'b0, 8'h5B, 4'h0, 2};
    tbl[6]  = '{8'h26, 1'b0, 8'h4F, 4'h0, 3};
    tbl[7]  = '{8'h25, 1'b0, 8'h66, 4'hA, 4};
    tbl[8]  = '{8'h16, 1'b0, 8'h06, 4'h0, 1};
    tbl[9]  = '{8'h1E, 1'b0, 8'h5B, 4'h0, 2};
    tbl[10] = '{8'h26, 1'b0, 8'h4F, 4'h0, 3};
    tbl[11] = '{8'h2E, 1'b0, 8'h6D, 4'hB, 4};
    tbl[12] = '{8'h16, 1'b0, 8'h06, 4'h0, 1};

    model_reset();
    repeat (5) @(negedge clkin);
    check_reset("rst_hold");
    rst = 1'b1;
    repeat (10000) @(negedge clkin);
    check_reset("idle");
    check("idle.keys", 64'(key_cnt), 64'd0);
    check("idle.ferr", 64'(ferr_cnt), 64'd0);

    for (int i = 0; i < 13; i++) begin
      set_flag(tbl[i].fl);
      kb = key_cnt;
      press(tbl[i].code);
      check($sformatf("tbl%0d.dout", i),    64'(dout),         64'(tbl[i].e_dout));
      check($sformatf("tbl%0d.jgout", i),   64'(jgout),        64'(tbl[i].e_jg));
      check($sformatf("tbl%0d.dig_cnt", i), 64'(dig_cnt),      64'(tbl[i].e_cnt));
      check($sformatf("tbl%0d.key_vld", i), 64'(key_cnt - kb), 64'd1);
    end

    // Bad parity on 0x16
    kb = key_cnt; fe = ferr_cnt;
    send_bits(mkframe(8'h16, 1'b1), 11);
`ifdef PS2_PARITY_CHK_EN
    m_ferr++;
    check("par.key_vld", 64'(key_cnt - kb), 64'd0);
    check("par.ferr",    64'(ferr_cnt - fe), 64'd1);
`else
    model_byte(8'h16);
    check("par.key_vld", 64'(key_cnt - kb), 64'd1);
    check("par.ferr",    64'(ferr_cnt - fe), 64'd0);
    check("par.dout",    64'(dout), 64'h06);
`endif
    check_model("par");
    send_byte(8'hF0);
    send_byte(8'h16);
    check_model("par_brk");

    // Timeout after five data bits
    fe = ferr_cnt;
    send_bits(mkframe(8'h45, 1'b0), 6);
    repeat (TO - 100) @(negedge clkin);
    check("to.early", 64'(ferr_cnt - fe), 64'd0);
    wait_cyc = 0;
    while (ferr_cnt == fe && wait_cyc < 400) begin
      @(negedge clkin);
      wait_cyc++;
    end
    m_ferr++;
    check("to.ferr", 64'(ferr_cnt - fe), 64'd1);
    press(8'h45);
    check("to.dout", 64'(dout), 64'h3F);
    check_model("to");

    // Unmapped make code
    c = m_cnt;
    press(8'h5A);
    check("unmap.dout", 64'(dout), 64'h00);
    check("unmap.dig_cnt", 64'(dig_cnt), 64'(c));
    check_model("unmap");

    // Reset in the middle of a frame
    set_flag(1'b0);
    send_bits(mkframe(8'h16, 1'b0), 4);
    rst = 1'b0;
    repeat (3) @(negedge clkin);
    check_reset("midrst");
    rst = 1'b1;
    model_reset();
    repeat (3) @(negedge clkin);
    press(8'h45);
    check("midrst.dout", 64'(dout), 64'h3F);
    check("midrst.dig_cnt", 64'(dig_cnt), 64'd1);
    check_model("midrst_after");

    // Random bytes and mode switches against the model
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 7) == 0) set_flag(!m_flag);
      case ($urandom_range(0, 9))
        0, 1, 2: b = HEXC[$urandom_range(0, 15)];
        3, 4, 5: b = HEXC[$urandom_range(1, 2)];
        6:       b = 8'hF0;
        7:       b = 8'hE0;
        8:       b = 8'h5A;
        default: b = 8'($urandom);
      endcase
      send_byte(b);
      check_model($sformatf("rnd%0d_%02h", i, b));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
